// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: one shared shift-add-3 binary-to-BCD engine serving two
// requesters through a round-robin scheduler. One operand bit is converted
// per clock; the four result digits are published together with a one-cycle
// done pulse tagged with the requester ID.
module bcd_conv_sched #(
   parameter int WIDTH = 13
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_valid_i,
   input  logic [WIDTH-1:0] num0_i,
   input  logic [WIDTH-1:0] num1_i,
   output logic [1:0]       req_ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             done_id_o,
   output logic [3:0]       thousands_o,
   output logic [3:0]       hundreds_o,
   output logic [3:0]       tens_o,
   output logic [3:0]       ones_o
);

   // Counter must hold the value WIDTH itself.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Shift-add-3 correction: a digit of 5 or more would overflow past 9 when
   // doubled, so pre-add 3 to carry it into the next digit instead.
   function automatic logic [3:0] add3_digit(input logic [3:0] dig);
      logic [3:0] res;
      if (dig >= 4'd5) begin
         res = dig + 4'd3;
      end else begin
         res = dig;
      end
      return res;
   endfunction

   // Shift the digit chain left by one, feeding the operand MSB into ones[0].
   // The thousands MSB is never set for operands up to 13 bits and drops out.
   function automatic logic [15:0] shift_chain(input logic [15:0] digs,
                                               input logic        msb);
      return {digs[14:0], msb};
   endfunction

   state_t           state_q, state_d;
   logic             last_id_q, last_id_d;
   logic             grant_id_q, grant_id_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [15:0]      work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             done_id_q, done_id_d;
   logic [15:0]      res_q, res_d;

   logic             grant_valid_s;
   logic             grant_sel_s;
   logic [15:0]      adj_s;
   logic [15:0]      chain_s;

   assign adj_s   = {add3_digit(work_q[15:12]), add3_digit(work_q[11:8]),
                     add3_digit(work_q[7:4]),   add3_digit(work_q[3:0])};
   assign chain_s = shift_chain(adj_s, op_q[WIDTH-1]);

   // Arbitration: single requester wins outright, a tie goes to whoever was
   // not served last. Only meaningful while idle.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_sel_s   = 1'b0;
      if (state_q == ST_IDLE) begin
         case (req_valid_i)
            2'b01: begin
               grant_valid_s = 1'b1;
               grant_sel_s   = 1'b0;
            end
            2'b10: begin
               grant_valid_s = 1'b1;
               grant_sel_s   = 1'b1;
            end
            2'b11: begin
               grant_valid_s = 1'b1;
               grant_sel_s   = ~last_id_q;
            end
            default: begin
               grant_valid_s = 1'b0;
               grant_sel_s   = 1'b0;
            end
         endcase
      end else begin
         grant_valid_s = 1'b0;
      end
   end

   // Next-state logic for the conversion FSM and its datapath.
   always_comb begin
      state_d    = state_q;
      last_id_d  = last_id_q;
      grant_id_d = grant_id_q;
      op_d       = op_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      done_id_d  = done_id_q;
      res_d      = res_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid_s) begin
               op_d       = grant_sel_s ? num1_i : num0_i;
               work_d     = 16'h0000;
               cnt_d      = CW'(WIDTH);
               last_id_d  = grant_sel_s;
               grant_id_d = grant_sel_s;
               state_d    = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            work_d = chain_s;
            op_d   = op_q << 1;
            cnt_d  = cnt_q - CW'(1);
            // Publish on entry to DONE so the digits and done pulse coincide
            // with the DONE cycle.
            if (cnt_q == CW'(1)) begin
               state_d   = ST_DONE;
               res_d     = chain_s;
               done_d    = 1'b1;
               done_id_d = grant_id_q;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         last_id_q  <= 1'b1;
         grant_id_q <= 1'b0;
         op_q       <= {WIDTH{1'b0}};
         work_q     <= 16'h0000;
         cnt_q      <= {CW{1'b0}};
         done_q     <= 1'b0;
         done_id_q  <= 1'b0;
         res_q      <= 16'h0000;
      end else begin
         state_q    <= state_d;
         last_id_q  <= last_id_d;
         grant_id_q <= grant_id_d;
         op_q       <= op_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         done_id_q  <= done_id_d;
         res_q      <= res_d;
      end
   end

   assign req_ready_o = grant_valid_s ? (grant_sel_s ? 2'b10 : 2'b01) : 2'b00;
   assign busy_o      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign done_o      = done_q;
   assign done_id_o   = done_id_q;
   assign thousands_o = res_q[15:12];
   assign hundreds_o  = res_q[11:8];
   assign tens_o      = res_q[7:4];
   assign ones_o      = res_q[3:0];

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: directed scenarios plus a
// randomized run checked against an arithmetic BCD / round-robin model.
module tb_bcd_conv_sched;
   localparam int WIDTH = 13;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic [1:0]       req_valid_i = 2'b00;
   logic [WIDTH-1:0] num0_i = '0;
   logic [WIDTH-1:0] num1_i = '0;
   logic [1:0]       req_ready_o;
   logic             busy_o, done_o, done_id_o;
   logic [3:0]       thousands_o, hundreds_o, tens_o, ones_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int          acc_cyc[$];
   int          acc_id[$];
   int          dn_cyc[$];
   int          dn_id[$];
   logic [15:0] dn_val[$];
   int          busy_cnt = 0;
   int          overlap_err = 0;
   logic [1:0]  last_ready = 2'b00;

   bcd_conv_sched #(.WIDTH(WIDTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i),
      .num0_i(num0_i), .num1_i(num1_i), .req_ready_o(req_ready_o),
      .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o),
      .thousands_o(thousands_o), .hundreds_o(hundreds_o),
      .tens_o(tens_o), .ones_o(ones_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp events.
   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle monitor logging accepts and results.
   always @(negedge clk) begin
      last_ready = req_ready_o;
      if (!rst_i) begin
         if (req_ready_o != 2'b00) begin
            acc_cyc.push_back(cyc);
            acc_id.push_back((req_ready_o == 2'b10) ? 1 : 0);
         end
         if ((req_ready_o != 2'b00) && busy_o) overlap_err++;
         if (req_ready_o == 2'b11) overlap_err++;
         if (busy_o) busy_cnt++;
         if (done_o) begin
            dn_cyc.push_back(cyc);
            dn_id.push_back(int'(done_id_o));
            dn_val.push_back({thousands_o, hundreds_o, tens_o, ones_o});
         end
      end
   end

   // Reference: decimal digits by plain division.
   function automatic logic [15:0] bcd_of(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      acc_cyc.delete(); acc_id.delete();
      dn_cyc.delete(); dn_id.delete(); dn_val.delete();
      busy_cnt = 0; overlap_err = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; req_valid_i = 2'b00;
      step(); step();
      rst_i = 1'b0;
      clear_logs();
   endtask

   // Run n cycles; optionally drop each valid bit once its accept is seen.
   task automatic drive_cycles(input int n, input bit drop);
      for (int i = 0; i < n; i++) begin
         step();
         if (drop) req_valid_i = req_valid_i & ~last_ready;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk); #1;
      n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
      n_checks++; if (done_id_o !== 1'b0) begin n_fail++; $display("FAIL reset_done_id: got %b want 0", done_id_o); end
      n_checks++; if ({thousands_o, hundreds_o, tens_o, ones_o} !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", {thousands_o, hundreds_o, tens_o, ones_o}); end
   endtask

   task automatic test_single();
      do_reset();
      num0_i = 13'd4095; req_valid_i = 2'b01;
      drive_cycles(20, 1'b1);
      n_checks++; if (acc_id.size() !== 1) begin n_fail++; $display("FAIL single_accepts: got %0d want 1", acc_id.size()); end
      n_checks++; if (dn_val.size() !== 1) begin n_fail++; $display("FAIL single_dones: got %0d want 1", dn_val.size()); end
      if (acc_id.size() >= 1 && dn_val.size() >= 1) begin
         n_checks++; if (acc_id[0] !== 0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", acc_id[0]); end
         n_checks++; if (dn_cyc[0] - acc_cyc[0] !== 14) begin n_fail++; $display("FAIL single_latency: got %0d want 14", dn_cyc[0] - acc_cyc[0]); end
         n_checks++; if (dn_val[0] !== bcd_of(4095)) begin n_fail++; $display("FAIL single_digits: got %h want %h", dn_val[0], bcd_of(4095)); end
         n_checks++; if (dn_id[0] !== 0) begin n_fail++; $display("FAIL single_id: got %0d want 0", dn_id[0]); end
      end
      n_checks++; if (busy_cnt !== 14) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 14", busy_cnt); end
   endtask

   task automatic test_tie();
      do_reset();
      num0_i = 13'd1234; num1_i = 13'd8191; req_valid_i = 2'b11;
      drive_cycles(40, 1'b1);
      n_checks++; if (dn_val.size() !== 2) begin n_fail++; $display("FAIL tie_dones: got %0d want 2", dn_val.size()); end
      if (dn_val.size() >= 2 && acc_cyc.size() >= 2) begin
         n_checks++; if (acc_id[0] !== 0 || acc_id[1] !== 1) begin n_fail++; $display("FAIL tie_grants: got %0d,%0d want 0,1", acc_id[0], acc_id[1]); end
         n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 15) begin n_fail++; $display("FAIL tie_second_accept: got +%0d want +15", acc_cyc[1] - acc_cyc[0]); end
         n_checks++; if (dn_cyc[0] - acc_cyc[0] !== 14) begin n_fail++; $display("FAIL tie_first_done: got +%0d want +14", dn_cyc[0] - acc_cyc[0]); end
         n_checks++; if (dn_cyc[1] - acc_cyc[0] !== 29) begin n_fail++; $display("FAIL tie_second_done: got +%0d want +29", dn_cyc[1] - acc_cyc[0]); end
         n_checks++; if (dn_val[0] !== bcd_of(1234) || dn_id[0] !== 0) begin n_fail++; $display("FAIL tie_result0: got %h id %0d want %h id 0", dn_val[0], dn_id[0], bcd_of(1234)); end
         n_checks++; if (dn_val[1] !== bcd_of(8191) || dn_id[1] !== 1) begin n_fail++; $display("FAIL tie_result1: got %h id %0d want %h id 1", dn_val[1], dn_id[1], bcd_of(8191)); end
      end
   endtask

   task automatic test_starvation();
      do_reset();
      num0_i = 13'd7; num1_i = 13'd42; req_valid_i = 2'b11;
      drive_cycles(62, 1'b0);
      req_valid_i = 2'b00;
      drive_cycles(20, 1'b0);
      n_checks++; if (dn_val.size() < 4) begin n_fail++; $display("FAIL starve_dones: got %0d want >=4", dn_val.size()); end
      for (int i = 0; i < 4; i++) begin
         if (dn_val.size() > i) begin
            n_checks++;
            if (dn_id[i] !== (i % 2) || dn_val[i] !== bcd_of((i % 2 == 0) ? 7 : 42)) begin
               n_fail++; $display("FAIL starve_result%0d: got %h id %0d want %h id %0d", i, dn_val[i], dn_id[i], bcd_of((i % 2 == 0) ? 7 : 42), i % 2);
            end
         end
      end
   endtask

   task automatic test_boundaries();
      int k;
      do_reset();
      num0_i = 13'd0; req_valid_i = 2'b01;
      drive_cycles(17, 1'b1);
      n_checks++; if (dn_val.size() !== 1 || dn_val[0] !== 16'h0000) begin n_fail++; $display("FAIL bound_zero: got %0d results, want one of 0000", dn_val.size()); end
      clear_logs();
      num0_i = 13'd8191; req_valid_i = 2'b01;
      drive_cycles(17, 1'b1);
      n_checks++; if (dn_val.size() !== 1 || dn_val[0] !== 16'h8191) begin n_fail++; $display("FAIL bound_max: got %0d results, want one of 8191", dn_val.size()); end
      clear_logs();
      k = 0;
      num0_i = 13'd9; req_valid_i = 2'b01;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_ready[0]) begin
            k++;
            if (k == 1) num0_i = 13'd10;
            else req_valid_i = 2'b00;
         end
      end
      n_checks++; if (dn_val.size() !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d want 2", dn_val.size()); end
      if (dn_val.size() >= 2) begin
         n_checks++; if (dn_val[0] !== bcd_of(9) || dn_val[1] !== bcd_of(10)) begin n_fail++; $display("FAIL b2b_digits: got %h,%h want 0009,0010", dn_val[0], dn_val[1]); end
         n_checks++; if (dn_cyc[1] - dn_cyc[0] !== 15) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 15", dn_cyc[1] - dn_cyc[0]); end
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      do_reset();
      num0_i = 13'd5555; req_valid_i = 2'b01;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (last_ready[0]) begin got = 1'b1; req_valid_i = 2'b00; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL rstmid_accept: got none want accept"); end
      drive_cycles(5, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_ctrl: got busy %b done %b ready %b want 0 0 00", busy_o, done_o, req_ready_o); end
      n_checks++; if ({thousands_o, hundreds_o, tens_o, ones_o, done_id_o} !== 17'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %h id %b want 0000 id 0", {thousands_o, hundreds_o, tens_o, ones_o}, done_id_o); end
      drive_cycles(20, 1'b1);
      n_checks++; if (dn_val.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d dones want 0", dn_val.size()); end
      clear_logs();
      num0_i = 13'd5555; req_valid_i = 2'b01;
      drive_cycles(20, 1'b1);
      n_checks++; if (dn_val.size() !== 1 || dn_val[0] !== bcd_of(5555)) begin n_fail++; $display("FAIL rstmid_fresh: got %0d results want one of 5555", dn_val.size()); end
   endtask

   task automatic test_isolation();
      bit changed;
      do_reset();
      num0_i = 13'd2468; req_valid_i = 2'b01;
      changed = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_ready[0]) req_valid_i[0] = 1'b0;
         if (busy_o && !changed) begin
            num0_i = 13'd1; req_valid_i = 2'b01; changed = 1'b1;
         end
      end
      n_checks++; if (dn_val.size() !== 2) begin n_fail++; $display("FAIL iso_dones: got %0d want 2", dn_val.size()); end
      if (dn_val.size() >= 2 && acc_cyc.size() >= 2) begin
         n_checks++; if (dn_val[0] !== bcd_of(2468)) begin n_fail++; $display("FAIL iso_result: got %h want 2468", dn_val[0]); end
         n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 15) begin n_fail++; $display("FAIL iso_reaccept: got +%0d want +15", acc_cyc[1] - acc_cyc[0]); end
         n_checks++; if (dn_val[1] !== bcd_of(1)) begin n_fail++; $display("FAIL iso_second: got %h want 0001", dn_val[1]); end
      end
      n_checks++; if (overlap_err !== 0) begin n_fail++; $display("FAIL iso_ready_while_busy: got %0d want 0", overlap_err); end
   endtask

   task automatic test_random();
      int          exp_id[$];
      logic [15:0] exp_val[$];
      int          last, p, a, b, first;
      do_reset();
      last = 1;
      for (int it = 0; it < 20; it++) begin
         p = $urandom_range(1, 3);
         a = $urandom_range(0, 8191);
         b = $urandom_range(0, 8191);
         num0_i = 13'(a); num1_i = 13'(b); req_valid_i = 2'(p);
         if (p == 3) begin
            first = 1 - last;
            exp_id.push_back(first); exp_val.push_back(bcd_of(first == 0 ? a : b));
            exp_id.push_back(1 - first); exp_val.push_back(bcd_of(first == 0 ? b : a));
            last = 1 - first;
         end else begin
            first = (p == 2) ? 1 : 0;
            exp_id.push_back(first); exp_val.push_back(bcd_of(first == 0 ? a : b));
            last = first;
         end
         drive_cycles(34, 1'b1);
      end
      n_checks++; if (dn_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", dn_val.size(), exp_val.size()); end
      for (int i = 0; i < exp_val.size(); i++) begin
         if (dn_val.size() > i) begin
            n_checks++;
            if (dn_val[i] !== exp_val[i] || dn_id[i] !== exp_id[i]) begin
               n_fail++; $display("FAIL rand_result%0d: got %h id %0d want %h id %0d", i, dn_val[i], dn_id[i], exp_val[i], exp_id[i]);
            end
         end
      end
      n_checks++; if (overlap_err !== 0) begin n_fail++; $display("FAIL rand_ready_while_busy: got %0d want 0", overlap_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_starvation();
      test_boundaries();
      test_reset_mid();
      test_isolation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Sequential, shared binary-to-BCD conversion engine with a two-port round-robin scheduler. It lets two display sources (e.g. PC readout and a data/register readout) share one shift-add-3 converter instead of instantiating two combinational converters. It converts one bit per clock and returns four BCD digits with a done pulse tagged by requester ID. The block sits between the CPU debug taps and the four-digit seven-segment driver.

## Interface
- WIDTH, 13, operand width in bits; legal range 1..13, so results always fit in four digits (max 8191).
- clk_i  input  1  system clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  2  bit k high = requester k has an operand pending.
- num0_i  input  WIDTH  operand of requester 0; sampled only on its accept cycle.
- num1_i  input  WIDTH  operand of requester 1; sampled only on its accept cycle.
- req_ready_o  output  2  one-hot accept strobe; bit k high = num<k>_i captured this cycle.
- busy_o  output  1  high while state is SHIFT or DONE.
- done_o  output  1  one-cycle pulse; digit outputs are updated this cycle.
- done_id_o  output  1  requester ID of the result on the digit outputs.
- thousands_o  output  4  BCD thousands digit, held until the next done_o.
- hundreds_o  output  4  BCD hundreds digit, held.
- tens_o  output  4  BCD tens digit, held.
- ones_o  output  4  BCD ones digit, held.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Arbitration:
  - Runs only in IDLE.
  - If exactly one req_valid_i bit is high, that requester is granted.
  - If both bits are high, the requester other than last_id is granted.
- Accept (IDLE with any valid):
  - req_ready_o[g] = 1 for that cycle only. It is combinational from state and req_valid_i.
  - Operand is loaded into the shift register; working digits are cleared; bit counter is set to WIDTH.
  - last_id and grant ID are set to g; next state is SHIFT.
- SHIFT, once per cycle:
  - First, each working digit that is ≥5 gets +3.
  - Then {thousands, hundreds, tens, ones, operand} shifts left one bit as a whole chain: the operand MSB enters ones[0], and each digit's bit 3 enters the next digit's bit 0.
  - The counter decrements. When the counter reaches 0, next state is DONE.
- DONE:
  - Working digits are copied to the output registers; done_id_o = grant ID; done_o = 1.
  - Next state is IDLE.
- Working-digit arithmetic is 4-bit unsigned. The thousands digit can never need adjustment for WIDTH ≤ 13, but the logic applies it anyway.
- Once captured, the operand is immune to changes on num*_i and req_valid_i.
- No request is ever accepted outside IDLE. Pending requesters simply wait, and no request is lost.
- Reset values: state IDLE, last_id = 1 (requester 0 wins the first tie), req_ready_o = 0, busy_o = 0, done_o = 0, done_id_o = 0, all digit outputs 0, counter 0.
- Reset mid-conversion: the conversion is abandoned, no done_o is produced, and outputs return to their reset values on the next edge.

## Timing
- Accept at cycle T (IDLE). SHIFT occupies cycles T+1 .. T+WIDTH. done_o is high and new digits are visible in cycle T+WIDTH+1.
- Latency from accept to done is WIDTH+1 cycles (14 for default).
- Earliest next accept is cycle T+WIDTH+2, so throughput is one conversion per WIDTH+2 cycles (15 for default).
- busy_o is high during T+1 .. T+WIDTH+1.
- req_ready_o is never high while busy_o is high.
- done_o and busy_o both fall in the cycle after DONE unless a new accept occurs there. In that cycle busy_o stays low, because the accept cycle itself is IDLE.
- Requester hold rule: keep req_valid_i and num<k>_i stable until req_ready_o[k] is seen. Deassert valid the cycle after the accept to avoid a second conversion.

## Test plan
- Single request, req 0, num0_i = 4095. Required: req_ready_o = 01 in the accept cycle; done_o exactly 14 cycles later with digits 4,0,9,5; done_id_o = 0; busy_o high for 14 cycles.
- Tie and fairness: both valid from reset, num0_i = 1234, num1_i = 8191, each dropped after its accept.
  - Requester 0 is served first: result 1,2,3,4 with id 0.
  - Its accept is at T0 and its done at T0+14. Requester 1 is accepted at T0+15.
  - Requester 1 result: 8,1,9,1 with id 1 at T0+29.
- Starvation check: both valid continuously with fixed operands 7 and 42. Grants must alternate 0,1,0,1; results alternate 0,0,0,7 and 0,0,4,2.
- Boundaries:
  - num0_i = 0 gives 0,0,0,0.
  - num0_i = 8191 gives 8,1,9,1.
  - num0_i = 9, then 10 (back-to-back, valid held), gives 0,0,0,9 then 0,0,1,0 at a 15-cycle spacing.
- Reset mid-operation: assert rst_i for one cycle, 6 cycles after accepting 5555. Required: no done_o; all outputs 0. A fresh 5555 request afterwards completes normally as 5,5,5,5.
- Operand isolation: change num0_i to 1 during SHIFT after accepting 2468. Result must be 2,4,6,8, and no extra accept may occur while busy_o is high.
